ace_inst_queue: RTL and testbench
=================================

// Module: ace_inst_queue
// PURPOSE
//  Parametrised fetch-to-decode instruction queue; next generation of the fixed 8-in/4-out buffer.
//  Accepts up to FETCH_W sparse-valid fetch lanes per cycle and compacts them in lane order.
//  Presents up to DEC_W oldest instructions to the decoders with a variable-count take.
//  Sits between the fetch unit and the dec_way decoder array.
// PARAMETERS
//  INST_W   32  instruction width in bits
//  FETCH_W  8   fetch lanes per cycle
//  DEC_W    4   decode lanes per cycle; must be <= DEPTH
//  DEPTH    16  entries; power of two, >= FETCH_W
// PORTS
//  clock         in   1                    single clock, rising edge
//  reset_n       in   1                    synchronous, active-low reset
//  flush_i       in   1                    retire flush; discards all contents
//  fetch_inst_i  in   FETCH_W*INST_W       lane k at [k*INST_W +: INST_W]
//  fetch_vld_i   in   FETCH_W              per-lane valid; any pattern allowed
//  fetch_rdy_o   out  1                    queue can accept a full FETCH_W group
//  dec_inst_o    out  DEC_W*INST_W         lane 0 = oldest entry
//  dec_vld_o     out  DEC_W                thermometer valid (lane j valid => lanes <j valid)
//  dec_take_i    in   $clog2(DEC_W+1)      number of lanes consumed this cycle (from lane 0)
//  count_o       out  $clog2(DEPTH+1)      current occupancy
//  full_o        out  1                    count_o == DEPTH
//  empty_o       out  1                    count_o == 0
// BEHAVIOUR
//  - State: head and tail pointers of $clog2(DEPTH) bits, and count. Pointers wrap modulo DEPTH.
//  - Reset (reset_n=0 at clock edge): head=tail=count=0. Outputs then read:
//    dec_vld_o=0, dec_inst_o=0, fetch_rdy_o=1, empty_o=1, full_o=0. Storage array is not reset.
//  - fetch_rdy_o = (DEPTH-count >= FETCH_W); it is a function of registered count only.
//  - Enqueue occurs when fetch_rdy_o && !flush_i. n_in = popcount(fetch_vld_i).
//    Valid lanes are written in ascending lane order to tail, tail+1, ... (mod DEPTH). tail += n_in.
//    If fetch_rdy_o=0, the group is dropped; fetch must hold and retry.
//  - Dequeue: dec_vld_o[j] = (j < count). dec_inst_o lane j = entry[head+j] if valid, else 0.
//    Output is combinational from registered state. Enqueue-to-visible latency is 1 cycle.
//  - n_take = min(dec_take_i, popcount(dec_vld_o)); an over-take is clamped (assertion fires in sim).
//    head += n_take.
//  - Simultaneous enqueue and take are allowed: count_next = count + n_in - n_take. Order is preserved.
//  - flush_i has priority over reset-free operation: next cycle head=tail=count=0.
//    Same-cycle enqueue and take are ignored. Flush while full or empty is legal.
//  - reset_n low mid-stream behaves as flush; reset has priority over flush.
//  - count_o, full_o and empty_o are derived from registered count, with no combinational input path.
// CONFIGURATION
//  ACE_IQ_BYPASS_EN defined: when count==0 and !flush_i, the compacted fetch lanes (first DEC_W) drive
//    dec_inst_o/dec_vld_o in the same cycle (0-cycle latency). n_take applies to those lanes first.
//    Only the n_in-n_take untaken instructions are written at tail. fetch_rdy_o rule is unchanged.
//  Not defined: no combinational fetch->decode path; latency is always 1 cycle.
// TESTING
//  1. reset_n=0 for 2 cycles -> empty_o=1, fetch_rdy_o=1, dec_vld_o=4'b0000, count_o=0.
//  2. From empty, fetch_vld_i=8'b1010_0101, lane k=32'h100+k, take 0 ->
//     next cycle dec_inst_o lanes = 100,102,105,107; dec_vld_o=4'b1111; count_o=4.
//  3. Two full groups of 8, no take -> count_o=16, full_o=1, fetch_rdy_o=0.
//     A third group is dropped; count_o stays 16.
//  4. count_o=8, full enqueue + dec_take_i=4 in the same cycle -> count_o=12, fetch_rdy_o=0.
//     Lane 0 shows the 5th-oldest entry.
//  5. Stream 3 in / 3 out per cycle for 40 cycles with random sparse valids ->
//     the output sequence matches the input sequence across pointer wrap; no loss or duplication.
//  6. count_o=10, assert flush_i with enqueue and dec_take_i=4 -> next cycle count_o=0, empty_o=1,
//     dec_vld_o=0. Also run with ACE_IQ_BYPASS_EN: from empty, enqueue 8 with take 4 ->
//     same cycle dec_vld_o=4'b1111, next cycle count_o=4.

Source files
------------

// File: rtl/ace_inst_queue_if.sv
// Fetch/decode handshake bundle for ace_inst_queue; the queue uses the slave
// modport and the fetch/decode side uses the master modport.
interface ace_inst_queue_if #(
  parameter int INST_W  = 32,
  parameter int FETCH_W = 8,
  parameter int DEC_W   = 4,
  parameter int DEPTH   = 16
);
  localparam int TAKE_W = $clog2(DEC_W + 1);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic                       flush_i;
  logic [FETCH_W*INST_W-1:0]  fetch_inst_i;
  logic [FETCH_W-1:0]         fetch_vld_i;
  logic                       fetch_rdy_o;
  logic [DEC_W*INST_W-1:0]    dec_inst_o;
  logic [DEC_W-1:0]           dec_vld_o;
  logic [TAKE_W-1:0]          dec_take_i;
  logic [CNT_W-1:0]           count_o;
  logic                       full_o;
  logic                       empty_o;

  modport slave (
    input  flush_i, fetch_inst_i, fetch_vld_i, dec_take_i,
    output fetch_rdy_o, dec_inst_o, dec_vld_o, count_o, full_o, empty_o
  );

  modport master (
    output flush_i, fetch_inst_i, fetch_vld_i, dec_take_i,
    input  fetch_rdy_o, dec_inst_o, dec_vld_o, count_o, full_o, empty_o
  );
endinterface

// File: rtl/ace_inst_queue.sv
// Fetch-to-decode instruction queue: compacts sparse fetch lanes, presents the oldest DEC_W entries.
// Define ACE_IQ_BYPASS_EN to let an empty queue forward fetch lanes straight to decode.
module ace_inst_queue #(
  parameter int INST_W  = 32,
  parameter int FETCH_W = 8,
  parameter int DEC_W   = 4,
  parameter int DEPTH   = 16
) (
  input logic             clock,
  input logic             reset_n,
  ace_inst_queue_if.slave q
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int TAKE_W = $clog2(DEC_W + 1);
  localparam int NIN_W  = $clog2(FETCH_W + 1);
  localparam int CMP_N  = (FETCH_W > DEC_W) ? FETCH_W : DEC_W;
  localparam int LANE_W = $clog2(CMP_N);

  logic [INST_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic [INST_W-1:0] comp [CMP_N];
  logic [NIN_W-1:0]  n_in;
  logic [NIN_W-1:0]  n_wr;
  logic [TAKE_W-1:0] n_avail;
  logic [TAKE_W-1:0] n_take;
  logic [TAKE_W-1:0] skip;
  logic [TAKE_W-1:0] n_deq;
  logic              fetch_rdy;
  logic              enq;
  logic              bypass;
  logic [DEC_W-1:0]  dec_vld;

  function automatic logic [TAKE_W-1:0] clamp_take(input logic [TAKE_W-1:0] req,
                                                   input logic [TAKE_W-1:0] avail);
    return (req > avail) ? avail : req;
  endfunction

  assign fetch_rdy = (count <= CNT_W'(DEPTH - FETCH_W));
  assign enq       = fetch_rdy && !q.flush_i;

`ifdef ACE_IQ_BYPASS_EN
  assign bypass = (count == '0) && !q.flush_i;
`else
  assign bypass = 1'b0;
`endif

  // Compact valid fetch lanes into consecutive slots, preserving lane order.
  always_comb begin
    n_in = '0;
    for (int k = 0; k < CMP_N; k++) comp[k] = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      if (q.fetch_vld_i[k]) begin
        comp[LANE_W'(n_in)] = q.fetch_inst_i[k*INST_W +: INST_W];
        n_in = n_in + NIN_W'(1);
      end
    end
  end

  always_comb begin
    if (bypass)
      n_avail = (n_in >= NIN_W'(DEC_W)) ? TAKE_W'(DEC_W) : TAKE_W'(n_in);
    else
      n_avail = (count >= CNT_W'(DEC_W)) ? TAKE_W'(DEC_W) : TAKE_W'(count);
  end

  assign n_take = clamp_take(q.dec_take_i, n_avail);
  // In bypass the taken lanes are never stored, so they are skipped on write and head stays put.
  assign skip   = bypass ? n_take : '0;
  assign n_deq  = bypass ? '0 : n_take;
  assign n_wr   = enq ? (n_in - NIN_W'(skip)) : '0;

  always_comb begin
    q.dec_inst_o = '0;
    for (int j = 0; j < DEC_W; j++) begin
      dec_vld[j] = (TAKE_W'(j) < n_avail);
      if (dec_vld[j])
        q.dec_inst_o[j*INST_W +: INST_W] = bypass ? comp[j] : mem[head + PTR_W'(j)];
    end
  end

  assign q.dec_vld_o   = dec_vld;
  assign q.fetch_rdy_o = fetch_rdy;
  assign q.count_o     = count;
  assign q.full_o      = (count == CNT_W'(DEPTH));
  assign q.empty_o     = (count == '0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (q.flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_deq);
      tail  <= tail + PTR_W'(n_wr);
      count <= count + CNT_W'(n_wr) - CNT_W'(n_deq);
    end
  end

  always_ff @(posedge clock) begin
    if (reset_n && enq) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (i >= int'(skip) && i < int'(n_in))
          mem[tail + PTR_W'(i) - PTR_W'(skip)] <= comp[i];
      end
    end
  end

  a_no_overtake: assert property (@(posedge clock) disable iff (!reset_n || q.flush_i)
                                  q.dec_take_i <= n_avail);

endmodule

// File: tb/tb_ace_inst_queue.sv
// Scoreboard bench for ace_inst_queue: stimulus pushes expected instructions,
// a negedge monitor pops and compares every lane the decoder takes.
module tb_ace_inst_queue;
  localparam int INST_W  = 32;
  localparam int FETCH_W = 8;
  localparam int DEC_W   = 4;
  localparam int DEPTH   = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   model_cnt = 0;
  logic [INST_W-1:0] sb [$];

  ace_inst_queue_if #(.INST_W(INST_W), .FETCH_W(FETCH_W), .DEC_W(DEC_W), .DEPTH(DEPTH)) bus();

  ace_inst_queue #(.INST_W(INST_W), .FETCH_W(FETCH_W), .DEC_W(DEC_W), .DEPTH(DEPTH)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .q       (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [INST_W-1:0] lane(input int j);
    return bus.dec_inst_o[j*INST_W +: INST_W];
  endfunction

  // Monitor: every lane the decoder takes must be the next expected instruction.
  always @(negedge clock) begin
    if (reset_n && !bus.flush_i) begin
      for (int j = 0; j < DEC_W; j++) begin
        if (j < int'(bus.dec_take_i)) begin
          if (sb.size() == 0) begin
            check("sb_underflow", 64'(lane(j)), 64'hDEAD);
          end else begin
            check("take_vld", 64'(bus.dec_vld_o[j]), 64'd1);
            check("take_data", 64'(lane(j)), 64'(sb.pop_front()));
          end
        end
      end
    end
  end

  task automatic drive(input logic [FETCH_W-1:0] vld, input logic [INST_W-1:0] base,
                       input int take, input bit flush);
    int nin;
    nin = 0;
    bus.fetch_vld_i = vld;
    for (int k = 0; k < FETCH_W; k++) bus.fetch_inst_i[k*INST_W +: INST_W] = base + INST_W'(k);
    bus.dec_take_i = 3'(take);
    bus.flush_i = flush;
    if (!flush && model_cnt <= DEPTH - FETCH_W) begin
      for (int k = 0; k < FETCH_W; k++) if (vld[k]) sb.push_back(base + INST_W'(k));
      nin = $countones(vld);
    end
    @(posedge clock); #1;
    if (flush) begin
      sb.delete();
      model_cnt = 0;
    end else begin
      model_cnt = model_cnt + nin - take;
    end
    bus.fetch_vld_i = '0;
    bus.dec_take_i = '0;
    bus.flush_i = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && model_cnt > 0; n++)
      drive('0, '0, (model_cnt < DEC_W) ? model_cnt : DEC_W, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush_i = 1'b0;
    bus.fetch_vld_i = '0;
    bus.fetch_inst_i = '0;
    bus.dec_take_i = '0;

    // Reset held for two cycles.
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_empty", 64'(bus.empty_o), 64'd1);
    check("rst_rdy", 64'(bus.fetch_rdy_o), 64'd1);
    check("rst_vld", 64'(bus.dec_vld_o), 64'd0);
    check("rst_count", 64'(bus.count_o), 64'd0);
    check("rst_full", 64'(bus.full_o), 64'd0);
    check("rst_inst", 64'(bus.dec_inst_o[63:0]), 64'd0);
    reset_n = 1'b1;

    // Sparse compaction.
    drive(8'b1010_0101, 32'h100, 0, 1'b0);
    check("cmp_l0", 64'(lane(0)), 64'h100);
    check("cmp_l1", 64'(lane(1)), 64'h102);
    check("cmp_l2", 64'(lane(2)), 64'h105);
    check("cmp_l3", 64'(lane(3)), 64'h107);
    check("cmp_vld", 64'(bus.dec_vld_o), 64'hF);
    check("cmp_count", 64'(bus.count_o), 64'd4);
    drain();

    // Fill to full, then a dropped group.
    drive(8'hFF, 32'h200, 0, 1'b0);
    drive(8'hFF, 32'h300, 0, 1'b0);
    check("full_count", 64'(bus.count_o), 64'd16);
    check("full_flag", 64'(bus.full_o), 64'd1);
    check("full_rdy", 64'(bus.fetch_rdy_o), 64'd0);
    drive(8'hFF, 32'h400, 0, 1'b0);
    check("drop_count", 64'(bus.count_o), 64'd16);
    drive('0, '0, 4, 1'b0);
    drive('0, '0, 4, 1'b0);
    check("half_count", 64'(bus.count_o), 64'd8);
    check("half_l0", 64'(lane(0)), 64'h300);

    // Simultaneous full enqueue and take of 4.
    drive(8'hFF, 32'h500, 4, 1'b0);
    check("sim_count", 64'(bus.count_o), 64'd12);
    check("sim_rdy", 64'(bus.fetch_rdy_o), 64'd0);
    check("sim_l0", 64'(lane(0)), 64'h304);
    drain();
    check("drain_empty", 64'(bus.empty_o), 64'd1);

    // Streaming across pointer wrap.
    for (int i = 0; i < 40; i++) begin
      logic [FETCH_W-1:0] v;
      v = '0;
      for (int r = 0; r < 3; r++) v[$urandom_range(0, FETCH_W-1)] = 1'b1;
      drive(v, 32'h1000 + 32'(i * 16), (model_cnt < 3) ? model_cnt : 3, 1'b0);
    end
    drain();
    check("stream_count", 64'(bus.count_o), 64'd0);
    check("stream_empty", 64'(bus.empty_o), 64'd1);

    // Flush with concurrent enqueue and take.
    drive(8'hFF, 32'h600, 0, 1'b0);
    drive(8'h03, 32'h700, 0, 1'b0);
    check("pre_flush_count", 64'(bus.count_o), 64'd10);
    drive(8'hFF, 32'h800, 4, 1'b1);
    check("flush_count", 64'(bus.count_o), 64'd0);
    check("flush_empty", 64'(bus.empty_o), 64'd1);
    check("flush_vld", 64'(bus.dec_vld_o), 64'd0);
    check("flush_rdy", 64'(bus.fetch_rdy_o), 64'd1);

    // Mid-stream reset acts as flush.
    drive(8'h0F, 32'hA00, 0, 1'b0);
    check("pre_rst_count", 64'(bus.count_o), 64'd4);
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    sb.delete();
    model_cnt = 0;
    check("mid_rst_count", 64'(bus.count_o), 64'd0);
    check("mid_rst_vld", 64'(bus.dec_vld_o), 64'd0);

`ifdef ACE_IQ_BYPASS_EN
    // Zero-latency forwarding from an empty queue.
    bus.fetch_vld_i = 8'hFF;
    for (int k = 0; k < FETCH_W; k++) begin
      bus.fetch_inst_i[k*INST_W +: INST_W] = 32'h900 + 32'(k);
      sb.push_back(32'h900 + 32'(k));
    end
    bus.dec_take_i = 3'd4;
    @(negedge clock);
    check("byp_vld", 64'(bus.dec_vld_o), 64'hF);
    check("byp_l0", 64'(lane(0)), 64'h900);
    @(posedge clock); #1;
    bus.fetch_vld_i = '0;
    bus.dec_take_i = '0;
    model_cnt = 4;
    check("byp_count", 64'(bus.count_o), 64'd4);
    check("byp_next_l0", 64'(lane(0)), 64'h904);
    drain();
`endif

    check("sb_left", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
